uart_bus_controller: RTL and testbench
======================================

// Module: uart_bus_controller
// PURPOSE
//  Memory-mapped front end of the UART. It decodes single-beat bus accesses into config registers, TX-queue pushes and RX-queue pops.
//  It latches sticky RX error flags and drives one level interrupt.
//  It sits between the core bus and the UART TX/RX controllers, baud generator and queues; it is the only writer of UART config.
// PARAMETERS
//  BAUD_DIV_W      16      width of baud divisor register/output
//  BAUD_DIV_RESET  16'd54  baud divisor value after reset
// PORTS
//  clk               in   1   system clock
//  reset             in   1   asynchronous, active-low reset
//  req               in   1   bus request; held until ack
//  we                in   1   1 = write, 0 = read
//  addr              in   5   byte address; addr[4:2] selects register, addr[1:0] ignored
//  wdata             in   32  write data
//  rdata             out  32  read data, valid while ack=1
//  ack               out  1   one-cycle completion pulse
//  tx_queue_full     in   1   TX queue cannot accept
//  tx_queue_we       out  1   one-cycle push strobe
//  tx_queue_wdata    out  8   byte pushed
//  rx_queue_empty    in   1   RX queue holds no byte
//  rx_queue_rdata    in   8   RX head byte, valid 1 cycle after rx_queue_re
//  rx_queue_re       out  1   one-cycle pop strobe
//  parity_error_if   in   1   pulse from RX path: parity mismatch
//  stop_bit_error_if in   1   pulse from RX path: bad stop bit
//  parity_en         out  1   CTRL[0]
//  parity_odd        out  1   CTRL[1]
//  double_stop_bit   out  1   CTRL[2]
//  baud_div          out  BAUD_DIV_W  BAUD register
//  irq               out  1   registered interrupt, level
// BEHAVIOUR
//  Map (addr[4:2]):
//    0 DATA: W pushes wdata[7:0]. R pops one byte: rdata = {rx_empty_at_req, 23'b0, byte}; byte = 0 if empty.
//    1 STATUS: R {27'b0, tx_ovr, stop_err, par_err, tx_full, rx_empty}; W1C bits [4:2].
//    2 CTRL (RW [2:0]); 3 BAUD (RW); 4 IRQ_EN (RW [3:0]: err, tx_not_full, rx_not_empty, timeout); 5 TIMEOUT (feature only).
//    Unmapped reads return 0; unmapped writes are ignored; all accesses are acked.
//  FSM IDLE/POP_WAIT/ACK; req is sampled only in IDLE.
//    IDLE, req: read DATA with !rx_queue_empty -> rx_queue_re=1, go POP_WAIT.
//      Any other access completes in this cycle (write/latch rdata) -> ACK.
//    POP_WAIT: rdata <= {1'b0, 23'b0, rx_queue_rdata} -> ACK.
//    ACK: ack=1 for one cycle -> IDLE. The requester drops req after seeing ack.
//  Latency: 2 cycles req->ack, 3 for a popping DATA read. rdata holds until the next ack.
//  DATA write with tx_queue_full: no push; tx_ovr set. Otherwise tx_queue_we=1 for exactly 1 cycle in IDLE.
//  Sticky flags set on input pulses from any state. A set pulse and a W1C in the same cycle: set wins.
//  irq <= |(IRQ_EN & {par_err|stop_err|tx_ovr, !tx_queue_full, !rx_queue_empty, tmo}); registered, 1-cycle lag.
//  Config writes take effect the cycle after the IDLE write cycle. Mid-frame changes are software's responsibility.
//  Reset (async assert, sync deassert at clk):
//    - all outputs and flags 0, baud_div=BAUD_DIV_RESET, FSM IDLE;
//    - a reset during POP_WAIT discards the popped byte.
// CONFIGURATION
//  UART_RX_TIMEOUT_EN defined:
//    - register 5 TIMEOUT [15:0] (RW, reset 0) and a 16-bit counter;
//    - the counter clears on a pop, while empty, or while TIMEOUT=0, otherwise increments per clk;
//    - on reaching TIMEOUT it sets sticky tmo, shown as STATUS[5] (W1C) and IRQ_EN[3].
//  Undefined: register 5 is unmapped, STATUS[5]=0, IRQ_EN[3] reads 0, tmo tied 0.
// STRUCTURE
//  uart_pkg: register offset localparams, STATUS/CTRL/IRQ bit indices, bus_state_t enum {IDLE, POP_WAIT, ACK}.
//  Sub-module uart_status_flags: sticky flags, W1C, optional timeout counter, irq register.
//  The top level holds the FSM, decode and config registers.
// TESTING
//  Reset: reset=0 mid-POP_WAIT -> ack=0, baud_div=54, irq=0, no queue strobe on release.
//  Write DATA 0x41, tx_queue_full=0 -> tx_queue_we 1 cycle with wdata 0x41, ack 2 cycles after req.
//    Repeat with full=1 -> no strobe, STATUS=0x10.
//  RX holds 0x5A, read DATA -> rx_queue_re 1 cycle, ack on cycle 3, rdata=0x0000005A.
//    Read again when empty -> rdata=0x80000000, no rx_queue_re.
//  parity_error_if pulse in the same cycle as W1C 0x4 to STATUS -> STATUS[2] stays 1. Next W1C clears it.
//  IRQ_EN=0x2, rx_queue_empty 1->0 -> irq rises one cycle later; falls one cycle after empty returns.
//  UART_RX_TIMEOUT_EN, TIMEOUT=10, byte waiting, no reads -> STATUS[5]=1 after 10 cycles. A pop before then -> no flag.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus front end: register map offsets,
// STATUS/CTRL/IRQ_EN bit positions and the bus FSM state type.
// Optional feature macro: UART_RX_TIMEOUT_EN (RX idle timeout register/flag).
package uart_pkg;

    // Register select values taken from addr[4:2]
    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_CTRL    = 3'd2;
    localparam logic [2:0] REG_BAUD    = 3'd3;
    localparam logic [2:0] REG_IRQ_EN  = 3'd4;
    localparam logic [2:0] REG_TIMEOUT = 3'd5;

    // STATUS bit positions
    localparam int ST_RX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_PAR_ERR  = 2;
    localparam int ST_STOP_ERR = 3;
    localparam int ST_TX_OVR   = 4;
    localparam int ST_TMO      = 5;

    // CTRL bit positions
    localparam int CTRL_PARITY_EN   = 0;
    localparam int CTRL_PARITY_ODD  = 1;
    localparam int CTRL_DOUBLE_STOP = 2;

    // IRQ_EN bit positions (MSB first: err, tx_not_full, rx_not_empty, timeout)
    localparam int IRQ_TMO          = 0;
    localparam int IRQ_RX_NOT_EMPTY = 1;
    localparam int IRQ_TX_NOT_FULL  = 2;
    localparam int IRQ_ERR          = 3;

    localparam int TIMEOUT_W = 16;

    // Without the timeout feature the timeout enable bit is not writable
`ifdef UART_RX_TIMEOUT_EN
    localparam logic [3:0] IRQ_EN_MASK = 4'hF;
`else
    localparam logic [3:0] IRQ_EN_MASK = 4'hE;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        POP_WAIT = 2'd1,
        ACK      = 2'd2
    } bus_state_t;

endpackage

// File: rtl/uart_status_flags.sv
// Sticky RX/TX error flags with write-one-to-clear, optional RX idle
// timeout counter and the registered level interrupt.
// Optional feature macro: UART_RX_TIMEOUT_EN.
module uart_status_flags
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 par_set,
    input  logic                 stop_set,
    input  logic                 ovr_set,
    input  logic                 w1c_en,
    input  logic [3:0]           w1c_bits,   // {tmo, tx_ovr, stop_err, par_err}
    input  logic                 tx_full,
    input  logic                 rx_empty,
    input  logic [3:0]           irq_en,
`ifdef UART_RX_TIMEOUT_EN
    input  logic                 rx_pop,
    input  logic [TIMEOUT_W-1:0] timeout_val,
`endif
    output logic                 par_err,
    output logic                 stop_err,
    output logic                 tx_ovr,
    output logic                 tmo,
    output logic                 irq
);

    logic par_err_q,  par_err_d;
    logic stop_err_q, stop_err_d;
    logic tx_ovr_q,   tx_ovr_d;
    logic irq_q,      irq_d;
    logic tmo_flag;

`ifdef UART_RX_TIMEOUT_EN
    logic                 tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 tmo_clear;
    logic                 tmo_set;

    // Idle counter: runs while a byte waits unread; parks at the limit so the
    // flag keeps being re-asserted until the byte is popped
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_clear = rx_pop || rx_empty || (timeout_val == '0);
        tmo_set   = 1'b0;
        if (tmo_clear) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == timeout_val) begin
            tmo_set = 1'b1;
        end else begin
            tmo_cnt_d = tmo_cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
        tmo_d = (tmo_q & ~(w1c_en & w1c_bits[3])) | tmo_set;
    end

    // Timeout counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign tmo_flag = tmo_q;
`else
    logic unused_w1c_tmo;
    assign unused_w1c_tmo = w1c_bits[3];
    assign tmo_flag       = 1'b0;
`endif

    // Sticky flags: a set pulse wins over a same-cycle clear
    always_comb begin
        par_err_d  = (par_err_q  & ~(w1c_en & w1c_bits[0])) | par_set;
        stop_err_d = (stop_err_q & ~(w1c_en & w1c_bits[1])) | stop_set;
        tx_ovr_d   = (tx_ovr_q   & ~(w1c_en & w1c_bits[2])) | ovr_set;
        irq_d      = |(irq_en & {par_err_q | stop_err_q | tx_ovr_q,
                                 ~tx_full, ~rx_empty, tmo_flag});
    end

    // Flag and interrupt registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            tx_ovr_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            tx_ovr_q   <= tx_ovr_d;
            irq_q      <= irq_d;
        end
    end

    assign par_err  = par_err_q;
    assign stop_err = stop_err_q;
    assign tx_ovr   = tx_ovr_q;
    assign tmo      = tmo_flag;
    assign irq      = irq_q;

endmodule

// File: rtl/uart_bus_controller.sv
// Memory-mapped UART front end: bus FSM, register decode and UART config.
// Optional feature macro: UART_RX_TIMEOUT_EN (adds TIMEOUT register 5).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for req; completes every access except a popping read
// POP_WAIT | pop strobe issued last cycle, capture RX head byte
// ACK      | one-cycle ack with rdata valid, then back to IDLE
module uart_bus_controller
    import uart_pkg::*;
#(
    parameter int                    BAUD_DIV_W     = 16,
    parameter logic [BAUD_DIV_W-1:0] BAUD_DIV_RESET = BAUD_DIV_W'(54)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [4:0]            addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ack,
    input  logic                  tx_queue_full,
    output logic                  tx_queue_we,
    output logic [7:0]            tx_queue_wdata,
    input  logic                  rx_queue_empty,
    input  logic [7:0]            rx_queue_rdata,
    output logic                  rx_queue_re,
    input  logic                  parity_error_if,
    input  logic                  stop_bit_error_if,
    output logic                  parity_en,
    output logic                  parity_odd,
    output logic                  double_stop_bit,
    output logic [BAUD_DIV_W-1:0] baud_div,
    output logic                  irq
);

    logic       rst_meta_q;
    logic       run_q;
    bus_state_t state_q, state_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [BAUD_DIV_W-1:0] baud_q, baud_d;
    logic [3:0]            irq_en_q, irq_en_d;
    logic [2:0]            reg_sel;
    logic [31:0]           rd_mux;
    logic                  push;
    logic                  pop;
    logic                  ovr_set;
    logic                  w1c_en;
    logic                  par_err;
    logic                  stop_err;
    logic                  tx_ovr;
    logic                  tmo;
    logic                  unused_bits;

`ifdef UART_RX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0]  timeout_q, timeout_d;
`endif

    assign reg_sel     = addr[4:2];
    assign unused_bits = ^{addr[1:0], wdata};

    // Reset synchronizer: assert immediately, release two edges after reset rises
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            run_q      <= rst_meta_q;
        end
    end

    // Read data multiplexer for accesses completed in IDLE
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_DATA:   rd_mux[31] = rx_queue_empty;
            REG_STATUS: rd_mux[5:0] = {tmo, tx_ovr, stop_err, par_err,
                                       tx_queue_full, rx_queue_empty};
            REG_CTRL:   rd_mux[2:0] = ctrl_q;
            REG_BAUD:   rd_mux[BAUD_DIV_W-1:0] = baud_q;
            REG_IRQ_EN: rd_mux[3:0] = irq_en_q;
`ifdef UART_RX_TIMEOUT_EN
            REG_TIMEOUT: rd_mux[TIMEOUT_W-1:0] = timeout_q;
`endif
            default:    rd_mux = '0;
        endcase
    end

    // Bus FSM next state, register writes and queue strobes
    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        ctrl_d   = ctrl_q;
        baud_d   = baud_q;
        irq_en_d = irq_en_q;
`ifdef UART_RX_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        push     = 1'b0;
        pop      = 1'b0;
        ovr_set  = 1'b0;
        w1c_en   = 1'b0;
        ack      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && run_q) begin
                    if (!we && reg_sel == REG_DATA && !rx_queue_empty) begin
                        pop     = 1'b1;
                        state_d = POP_WAIT;
                    end else begin
                        state_d = ACK;
                        rdata_d = '0;
                        if (we) begin
                            case (reg_sel)
                                REG_DATA: begin
                                    if (tx_queue_full) ovr_set = 1'b1;
                                    else               push    = 1'b1;
                                end
                                REG_STATUS: w1c_en   = 1'b1;
                                REG_CTRL:   ctrl_d   = wdata[2:0];
                                REG_BAUD:   baud_d   = wdata[BAUD_DIV_W-1:0];
                                REG_IRQ_EN: irq_en_d = wdata[3:0] & IRQ_EN_MASK;
`ifdef UART_RX_TIMEOUT_EN
                                REG_TIMEOUT: timeout_d = wdata[TIMEOUT_W-1:0];
`endif
                                default: ;
                            endcase
                        end else begin
                            rdata_d = rd_mux;
                        end
                    end
                end
            end
            POP_WAIT: begin
                rdata_d = {24'b0, rx_queue_rdata};
                state_d = ACK;
            end
            ACK: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, read data and configuration registers
    always_ff @(posedge clk or negedge run_q) begin
        if (!run_q) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            ctrl_q   <= '0;
            baud_q   <= BAUD_DIV_RESET;
            irq_en_q <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            ctrl_q   <= ctrl_d;
            baud_q   <= baud_d;
            irq_en_q <= irq_en_d;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    // Timeout limit register
    always_ff @(posedge clk or negedge run_q) begin
        if (!run_q) timeout_q <= '0;
        else        timeout_q <= timeout_d;
    end
`endif

    uart_status_flags u_flags (
        .clk         (clk),
        .rst_n       (run_q),
        .par_set     (parity_error_if),
        .stop_set    (stop_bit_error_if),
        .ovr_set     (ovr_set),
        .w1c_en      (w1c_en),
        .w1c_bits    (wdata[5:2]),
        .tx_full     (tx_queue_full),
        .rx_empty    (rx_queue_empty),
        .irq_en      (irq_en_q),
`ifdef UART_RX_TIMEOUT_EN
        .rx_pop      (pop),
        .timeout_val (timeout_q),
`endif
        .par_err     (par_err),
        .stop_err    (stop_err),
        .tx_ovr      (tx_ovr),
        .tmo         (tmo),
        .irq         (irq)
    );

    assign rdata           = rdata_q;
    assign tx_queue_we     = push;
    assign tx_queue_wdata  = push ? wdata[7:0] : 8'h00;
    assign rx_queue_re     = pop;
    assign parity_en       = ctrl_q[CTRL_PARITY_EN];
    assign parity_odd      = ctrl_q[CTRL_PARITY_ODD];
    assign double_stop_bit = ctrl_q[CTRL_DOUBLE_STOP];
    assign baud_div        = baud_q;

endmodule

// File: tb/tb_uart_bus_controller.sv
// Scoreboard bench for uart_bus_controller: bus stimulus pushes expected
// read data / TX bytes into queues, a negedge monitor pops and compares.
module tb_uart_bus_controller;

    localparam logic [4:0] A_DATA    = 5'h00;
    localparam logic [4:0] A_STATUS  = 5'h04;
    localparam logic [4:0] A_CTRL    = 5'h08;
    localparam logic [4:0] A_BAUD    = 5'h0C;
    localparam logic [4:0] A_IRQ_EN  = 5'h10;
    localparam logic [4:0] A_TIMEOUT = 5'h14;
    localparam logic [4:0] A_UNMAP6  = 5'h18;
    localparam logic [4:0] A_UNMAP7  = 5'h1C;

`ifdef UART_RX_TIMEOUT_EN
    localparam logic [31:0] TMO_BIT = 32'h20;
    localparam logic [31:0] TMO_RB  = 32'd10;
`else
    localparam logic [31:0] TMO_BIT = 32'h0;
    localparam logic [31:0] TMO_RB  = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [4:0]  addr;
    logic [31:0] wdata, rdata;
    logic        ack;
    logic        tx_queue_full, tx_queue_we;
    logic [7:0]  tx_queue_wdata;
    logic        rx_queue_empty;
    logic [7:0]  rx_queue_rdata;
    logic        rx_queue_re;
    logic        parity_error_if, stop_bit_error_if;
    logic        parity_en, parity_odd, double_stop_bit;
    logic [15:0] baud_div;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    int tx_we_cnt = 0;
    int rx_re_cnt = 0;
    logic [31:0] exp_rd_q[$];
    logic [7:0]  exp_tx_q[$];

    always #5 clk = ~clk;

    uart_bus_controller dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .we                (we),
        .addr              (addr),
        .wdata             (wdata),
        .rdata             (rdata),
        .ack               (ack),
        .tx_queue_full     (tx_queue_full),
        .tx_queue_we       (tx_queue_we),
        .tx_queue_wdata    (tx_queue_wdata),
        .rx_queue_empty    (rx_queue_empty),
        .rx_queue_rdata    (rx_queue_rdata),
        .rx_queue_re       (rx_queue_re),
        .parity_error_if   (parity_error_if),
        .stop_bit_error_if (stop_bit_error_if),
        .parity_en         (parity_en),
        .parity_odd        (parity_odd),
        .double_stop_bit   (double_stop_bit),
        .baud_div          (baud_div),
        .irq               (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: count strobes, compare pushed bytes and acked read data
    always @(negedge clk) begin
        if (tx_queue_we === 1'b1) begin
            tx_we_cnt++;
            if (exp_tx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_push_unexpected: got 0x%02h, expected no push", tx_queue_wdata);
            end else begin
                check("tx_push_data", {24'b0, tx_queue_wdata}, {24'b0, exp_tx_q.pop_front()});
            end
        end
        if (rx_queue_re === 1'b1) rx_re_cnt++;
        if (ack === 1'b1) begin
            if (exp_rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL ack_unexpected: got rdata 0x%08h, expected no ack", rdata);
            end else begin
                check("ack_rdata", rdata, exp_rd_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus access; called and returns at posedge+1
    task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input int exp_lat,
                       input logic par_pulse, input string name);
        int  cyc = 0;
        bit  got = 0;
        exp_rd_q.push_back(exp_rd);
        req = 1'b1; we = w; addr = a; wdata = d;
        if (par_pulse) parity_error_if = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            cyc = i;
            if (ack) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
            parity_error_if = 1'b0;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_ack_timeout: got no ack in 20 cycles, expected ack", name);
            exp_rd_q.delete();
        end else begin
            check({name, "_latency"}, cyc, exp_lat);
        end
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; parity_error_if = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input string name);
        bus(1'b1, a, d, 32'h0, 2, 1'b0, name);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input int lat, input string name);
        bus(1'b0, a, 32'h0, exp, lat, 1'b0, name);
    endtask

    int c0;

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tx_queue_full = 1'b0; rx_queue_empty = 1'b1; rx_queue_rdata = 8'h00;
        parity_error_if = 1'b0; stop_bit_error_if = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(4);

        check("rst_ack", ack, 0);
        check("rst_baud", baud_div, 54);
        check("rst_irq", irq, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ctrl", {parity_en, parity_odd, double_stop_bit}, 0);

        // TX push and overrun
        c0 = tx_we_cnt;
        exp_tx_q.push_back(8'h41);
        wr(A_DATA, 32'h41, "wr_data");
        check("tx_push_count", tx_we_cnt - c0, 1);
        tx_queue_full = 1'b1;
        c0 = tx_we_cnt;
        wr(A_DATA, 32'h99, "wr_data_full");
        check("tx_full_no_push", tx_we_cnt - c0, 0);
        tx_queue_full = 1'b0;
        rx_queue_empty = 1'b0;
        rx_queue_rdata = 8'h5A;
        rd(A_STATUS, 32'h10, 2, "status_ovr");

        // RX pop and empty read
        c0 = rx_re_cnt;
        rd(A_DATA, 32'h0000_005A, 3, "rd_pop");
        check("rx_pop_count", rx_re_cnt - c0, 1);
        rx_queue_empty = 1'b1;
        c0 = rx_re_cnt;
        rd(A_DATA, 32'h8000_0000, 2, "rd_empty");
        check("rx_no_pop", rx_re_cnt - c0, 0);

        // W1C and set-wins collision
        wr(A_STATUS, 32'h10, "w1c_ovr");
        rd(A_STATUS, 32'h01, 2, "status_clr");
        bus(1'b1, A_STATUS, 32'h4, 32'h0, 2, 1'b1, "w1c_par_collide");
        rd(A_STATUS, 32'h05, 2, "status_par_kept");
        wr(A_STATUS, 32'h4, "w1c_par");
        rd(A_STATUS, 32'h01, 2, "status_par_clr");

        // Config registers and unmapped space
        wr(A_CTRL, 32'hFFFF_FFF5, "wr_ctrl");
        check("ctrl_outs", {parity_en, parity_odd, double_stop_bit}, 3'b101);
        rd(A_CTRL | 5'h3, 32'h5, 2, "rd_ctrl_lowaddr");
        wr(A_BAUD, 32'h0000_1234, "wr_baud");
        check("baud_out", baud_div, 16'h1234);
        rd(A_BAUD, 32'h1234, 2, "rd_baud");
        rd(A_UNMAP6, 32'h0, 2, "rd_unmapped");
        wr(A_UNMAP7, 32'hFFFF_FFFF, "wr_unmapped");
        rd(A_CTRL, 32'h5, 2, "rd_ctrl_after_unmapped");

        // Level interrupt on rx_not_empty
        wr(A_IRQ_EN, 32'h2, "wr_irq_en");
        cycles(1);
        check("irq_idle", irq, 0);
        rx_queue_empty = 1'b0;
        @(negedge clk);
        check("irq_lag_rise", irq, 0);
        @(negedge clk);
        check("irq_rise", irq, 1);
        @(posedge clk);
        #1;
        rx_queue_empty = 1'b1;
        @(negedge clk);
        check("irq_lag_fall", irq, 1);
        @(negedge clk);
        check("irq_fall", irq, 0);
        @(posedge clk);
        #1;
        rd(A_IRQ_EN, 32'h2, 2, "rd_irq_en");

        // Error interrupt from a stop bit error pulse
        wr(A_IRQ_EN, 32'h8, "wr_irq_en_err");
        cycles(2);
        check("irq_err_idle", irq, 0);
        stop_bit_error_if = 1'b1;
        cycles(1);
        stop_bit_error_if = 1'b0;
        cycles(1);
        check("irq_err", irq, 1);
        rd(A_STATUS, 32'h09, 2, "status_stop");
        wr(A_STATUS, 32'h8, "w1c_stop");
        cycles(2);
        check("irq_err_clr", irq, 0);

        // Reset while waiting for the popped byte
        wr(A_IRQ_EN, 32'h2, "wr_irq_en_pre_rst");
        rx_queue_empty = 1'b0;
        rx_queue_rdata = 8'hC3;
        cycles(2);
        check("irq_pre_rst", irq, 1);
        c0 = rx_re_cnt;
        req = 1'b1; we = 1'b0; addr = A_DATA;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req = 1'b0;
        #1;
        check("rst_mid_ack", ack, 0);
        check("rst_mid_baud", baud_div, 54);
        check("rst_mid_irq", irq, 0);
        check("rst_mid_rdata", rdata, 0);
        check("rst_mid_pop_count", rx_re_cnt - c0, 1);
        cycles(2);
        reset = 1'b1;
        c0 = rx_re_cnt + tx_we_cnt;
        cycles(6);
        check("rst_release_no_strobe", rx_re_cnt + tx_we_cnt - c0, 0);
        check("rst_release_irq", irq, 0);
        check("rst_release_ack", ack, 0);
        rd(A_STATUS, 32'h00, 2, "status_after_rst");

        // RX idle timeout
        rx_queue_empty = 1'b1;
        wr(A_TIMEOUT, 32'd10, "wr_timeout");
        rd(A_TIMEOUT, TMO_RB, 2, "rd_timeout");
        rx_queue_empty = 1'b0;
        cycles(4);
        rd(A_STATUS, 32'h00, 2, "status_tmo_early");
        cycles(8);
        rd(A_STATUS, TMO_BIT, 2, "status_tmo");
        rx_queue_empty = 1'b1;
        wr(A_STATUS, 32'h20, "w1c_tmo");
        rd(A_STATUS, 32'h01, 2, "status_tmo_clr");
        rx_queue_rdata = 8'h5A;
        rx_queue_empty = 1'b0;
        cycles(5);
        rd(A_DATA, 32'h5A, 3, "rd_pop_before_tmo");
        rx_queue_empty = 1'b1;
        cycles(12);
        rd(A_STATUS, 32'h01, 2, "status_no_tmo");

        cycles(3);
        check("scoreboard_rd_drained", exp_rd_q.size(), 0);
        check("scoreboard_tx_drained", exp_tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "time limit");
    end

endmodule
